// File: rtl/fetch_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter_pkg
// Shared types and constants for the IF/MEM unified-RAM arbiter.
//   arb_state_t : arbiter FSM state encoding
//   arb_owner_t : which requester currently owns the RAM
//   CNT_W       : width of the access-latency counter (MEM_LAT up to 15)
//   is_busy()   : true while the RAM is being driven
// ---------------------------------------------------------------------------
package fetch_mem_arbiter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BUSY_IF  = 3'd1,
      BUSY_MEM = 3'd2,
      DONE_IF  = 3'd3,
      DONE_MEM = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } arb_owner_t;

   function automatic logic is_busy(arb_state_t s);
      return (s == BUSY_IF) || (s == BUSY_MEM);
   endfunction

endpackage

// File: rtl/fetch_mem_arbiter_lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Loadable down-counter with a zero flag. Counts the remaining RAM access
// cycles of the transfer in flight. Saturates at zero.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset (count -> 0)
//   i_load        : load i_load_val (has priority over decrement)
//   i_load_val    : value to load
//   i_dec         : decrement by one when nonzero
//   o_count       : current count
//   o_zero        : count == 0
// ---------------------------------------------------------------------------
module lat_counter #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter
// Shares one single-ported instruction/data RAM between the IF stage and the
// MEM stage. Each access drives the RAM for MEM_LAT cycles, then spends one
// cycle in a DONE state raising the requester's valid pulse. MEM wins over IF
// when both are waiting in IDLE (it belongs to the older instruction).
//
// Handshake (both requesters): a request is a level held until the matching
// o_*_valid pulse; the pulse lasts exactly one cycle and marks completion.
// o_*_freeze = request & ~valid, so the stage stalls until that pulse. A
// request dropped mid-access does not abort it. A killed fetch (i_if_kill)
// completes on the RAM but produces no o_if_valid and no data update.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_if_req/addr/kill     fetch request, PC, branch-taken kill
//   o_if_data/valid/freeze fetched instruction, completion pulse, PC stall
//   i_mem_rd_en/wr_en      load / store request (both set = store)
//   i_mem_addr/wdata       load/store address, store data
//   o_mem_rdata/valid      load data, completion pulse (loads and stores)
//   o_mem_freeze           MEM-stage stall
//   o_ram_en/wr/addr/wdata RAM strobe, write strobe, address, write data
//   i_ram_rdata            RAM read data, valid by last access cycle
//   o_dbg_state/dbg_cnt    FSM state and latency counter, for observation
// ---------------------------------------------------------------------------
module fetch_mem_arbiter
   import fetch_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_if_kill,
   output logic [DATA_W-1:0] o_if_data,
   output logic              o_if_valid,
   output logic              o_if_freeze,
   input  logic              i_mem_rd_en,
   input  logic              i_mem_wr_en,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] o_mem_rdata,
   output logic              o_mem_valid,
   output logic              o_mem_freeze,
   output logic              o_ram_en,
   output logic              o_ram_wr,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic [2:0]        o_dbg_state,
   output logic [CNT_W-1:0]  o_dbg_cnt
);

   // Counter starts at MEM_LAT-1 so that it reads zero in the last access cycle.
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   arb_state_t        r_state;
   arb_owner_t        r_owner;
   logic              r_wr;
   logic              r_kill;
   logic              r_ram_en;
   logic              r_ram_wr;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic [DATA_W-1:0] r_if_data;
   logic [DATA_W-1:0] r_mem_rdata;
   logic              r_if_valid;
   logic              r_mem_valid;

   logic              w_mem_req;
   logic              w_start;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic [CNT_W-1:0]  w_cnt;

   assign w_mem_req = i_mem_rd_en | i_mem_wr_en;
   assign w_start   = (r_state == IDLE) && (w_mem_req || i_if_req);
   assign w_cnt_dec = is_busy(r_state);

   lat_counter #(
      .W(CNT_W)
   ) u_lat_counter (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_start),
      .i_load_val (LAT_LOAD),
      .i_dec      (w_cnt_dec),
      .o_count    (w_cnt),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_IF;
         r_wr        <= 1'b0;
         r_kill      <= 1'b0;
         r_ram_en    <= 1'b0;
         r_ram_wr    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_if_data   <= '0;
         r_mem_rdata <= '0;
         r_if_valid  <= 1'b0;
         r_mem_valid <= 1'b0;
      end else begin
         // Valid pulses are only ever set on the edge into DONE_x.
         r_if_valid  <= 1'b0;
         r_mem_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_mem_req) begin
                  r_state     <= BUSY_MEM;
                  r_owner     <= OWN_MEM;
                  r_wr        <= i_mem_wr_en;
                  r_ram_en    <= 1'b1;
                  r_ram_wr    <= i_mem_wr_en;
                  r_ram_addr  <= i_mem_addr;
                  r_ram_wdata <= i_mem_wdata;
               end else if (i_if_req) begin
                  r_state    <= BUSY_IF;
                  r_owner    <= OWN_IF;
                  r_wr       <= 1'b0;
                  r_ram_en   <= 1'b1;
                  r_ram_wr   <= 1'b0;
                  r_ram_addr <= i_if_addr;
                  // A kill on the very edge that starts the fetch counts too.
                  r_kill     <= i_if_kill;
               end
            end
            BUSY_IF, BUSY_MEM: begin
               if ((r_owner == OWN_IF) && i_if_kill) begin
                  r_kill <= 1'b1;
               end
               if (w_cnt_zero) begin
                  r_ram_en <= 1'b0;
                  r_ram_wr <= 1'b0;
                  if (r_owner == OWN_MEM) begin
                     r_state     <= DONE_MEM;
                     r_mem_valid <= 1'b1;
                     if (!r_wr) begin
                        r_mem_rdata <= i_ram_rdata;
                     end
                  end else begin
                     r_state <= DONE_IF;
                     // Kill seen on this final edge suppresses the result as well.
                     if (!(r_kill || i_if_kill)) begin
                        r_if_valid <= 1'b1;
                        r_if_data  <= i_ram_rdata;
                     end
                  end
               end
            end
            DONE_IF: begin
               r_kill  <= 1'b0;
               r_state <= IDLE;
            end
            DONE_MEM: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_if_data    = r_if_data;
   assign o_if_valid   = r_if_valid;
   assign o_if_freeze  = i_if_req & ~r_if_valid;
   assign o_mem_rdata  = r_mem_rdata;
   assign o_mem_valid  = r_mem_valid;
   assign o_mem_freeze = w_mem_req & ~r_mem_valid;
   assign o_ram_en     = r_ram_en;
   assign o_ram_wr     = r_ram_wr;
   assign o_ram_addr   = r_ram_addr;
   assign o_ram_wdata  = r_ram_wdata;
   assign o_dbg_state  = r_state;
   assign o_dbg_cnt    = w_cnt;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fetch_mem_arbiter
// Three arbiters (MEM_LAT = 2, 1, 15) share stimulus; 'sel' picks which one
// receives requests and is observed. Expected behaviour comes from a
// transaction-level model: the arbiter is free at some edge, serves MEM first
// then IF, each service takes MEM_LAT busy cycles plus a DONE cycle and one
// idle cycle, and a reference memory supplies expected read data.
// ---------------------------------------------------------------------------
module tb_fetch_mem_arbiter;
   import fetch_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [1:0]  sel;
   logic        if_req, if_kill, mem_rd, mem_wr;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] ram_rdata;

   logic [2:0][31:0] d_if_data, d_mem_rdata, d_ram_addr, d_ram_wdata;
   logic [2:0]       d_if_valid, d_if_freeze, d_mem_valid, d_mem_freeze, d_ram_en, d_ram_wr;
   logic [2:0][2:0]  d_state;
   logic [2:0][3:0]  d_cnt;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      fetch_mem_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LAT((k == 0) ? 2 : ((k == 1) ? 1 : 15))
      ) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_if_req    (if_req  && (sel == 2'(k))),
         .i_if_addr   (if_addr),
         .i_if_kill   (if_kill && (sel == 2'(k))),
         .o_if_data   (d_if_data[k]),
         .o_if_valid  (d_if_valid[k]),
         .o_if_freeze (d_if_freeze[k]),
         .i_mem_rd_en (mem_rd  && (sel == 2'(k))),
         .i_mem_wr_en (mem_wr  && (sel == 2'(k))),
         .i_mem_addr  (mem_addr),
         .i_mem_wdata (mem_wdata),
         .o_mem_rdata (d_mem_rdata[k]),
         .o_mem_valid (d_mem_valid[k]),
         .o_mem_freeze(d_mem_freeze[k]),
         .o_ram_en    (d_ram_en[k]),
         .o_ram_wr    (d_ram_wr[k]),
         .o_ram_addr  (d_ram_addr[k]),
         .o_ram_wdata (d_ram_wdata[k]),
         .i_ram_rdata (ram_rdata),
         .o_dbg_state (d_state[k]),
         .o_dbg_cnt   (d_cnt[k])
      );
   end

   logic [31:0] ob_if_data, ob_mem_rdata, ob_ram_addr, ob_ram_wdata;
   logic        ob_if_valid, ob_if_freeze, ob_mem_valid, ob_mem_freeze, ob_ram_en, ob_ram_wr;
   logic [2:0]  ob_state;
   logic [3:0]  ob_cnt;
   assign ob_if_data    = d_if_data[sel];
   assign ob_mem_rdata  = d_mem_rdata[sel];
   assign ob_ram_addr   = d_ram_addr[sel];
   assign ob_ram_wdata  = d_ram_wdata[sel];
   assign ob_if_valid   = d_if_valid[sel];
   assign ob_if_freeze  = d_if_freeze[sel];
   assign ob_mem_valid  = d_mem_valid[sel];
   assign ob_mem_freeze = d_mem_freeze[sel];
   assign ob_ram_en     = d_ram_en[sel];
   assign ob_ram_wr     = d_ram_wr[sel];
   assign ob_state      = d_state[sel];
   assign ob_cnt        = d_cnt[sel];

   // Initial memory contents, with a few fixed words used by directed tests.
   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a == 32'h10)  return 32'hE3A01005;
      if (a == 32'h20)  return 32'h12345678;
      if (a == 32'h400) return 32'h00000055;
      return ((a * 32'h9E3779B1) ^ 32'hA5A50F0F);
   endfunction

   function automatic int lat_of(input logic [1:0] s);
      return (s == 2'd0) ? 2 : ((s == 2'd1) ? 1 : 15);
   endfunction

   // RAM model driven by the selected arbiter's RAM port.
   logic [31:0] ram_mem  [1024];
   logic        ram_seen [1024];
   always @(negedge clk) begin
      if (ob_ram_en && ob_ram_wr) begin
         ram_mem[ob_ram_addr[11:2]]  <= ob_ram_wdata;
         ram_seen[ob_ram_addr[11:2]] <= 1'b1;
      end
      ram_rdata <= ram_seen[ob_ram_addr[11:2]] ? ram_mem[ob_ram_addr[11:2]] : init_val(ob_ram_addr);
   end

   // Reference memory and expected output registers per arbiter.
   logic [31:0] ref_mem [1024];
   logic [31:0] exp_if_data   [3];
   logic [31:0] exp_mem_rdata [3];

   // One access scenario on the selected arbiter. if_at / mem_at: edge at which
   // the request is first present (-1 = none). kill_off: kill pulse edge relative
   // to the fetch start (-99 = none). Returns first observed valid edges and
   // the number of RAM enable / write cycles seen.
   task automatic run_scn(input int if_at, input int mem_at, input bit m_wr, input bit m_both,
                          input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                          input int kill_off,
                          output int ov_if, output int ov_mem, output int o_en, output int o_wr);
      int lat, free, if_s, mem_s, v_if, v_mem, kill_e, drop_if, last_e;
      bit if_pend, mem_pend, killed, b_if, b_mem, x_en, x_wr, x_ifv, x_memv, x_iff, x_mf;
      logic [31:0] if_exp, mem_exp, x_addr;
      lat = lat_of(sel);
      if_s = -1; mem_s = -1; free = 0; if_exp = '0; mem_exp = '0;
      if_pend = (if_at >= 0); mem_pend = (mem_at >= 0);
      for (int t = 0; t < 200 && (if_pend || mem_pend); t++) begin
         if (t >= free) begin
            if (mem_pend && t >= mem_at) begin
               mem_s = t; mem_pend = 0; free = t + lat + 2;
               if (m_wr) ref_mem[ma[11:2]] = wd;
               else      mem_exp = ref_mem[ma[11:2]];
            end else if (if_pend && t >= if_at) begin
               if_s = t; if_pend = 0; free = t + lat + 2;
               if_exp = ref_mem[ia[11:2]];
            end
         end
      end
      v_if   = (if_s  >= 0) ? if_s + lat : -1;
      v_mem  = (mem_s >= 0) ? mem_s + lat : -1;
      kill_e = (if_s >= 0 && kill_off != -99) ? if_s + kill_off : -1;
      killed = (if_s >= 0) && (kill_off >= 0) && (kill_off <= lat);
      drop_if = killed ? kill_e : v_if;
      last_e  = ((v_if > v_mem) ? v_if : v_mem) + 1;
      ov_if = -1; ov_mem = -1; o_en = 0; o_wr = 0;
      for (int e = 0; e <= last_e; e++) begin
         if_addr = ia; mem_addr = ma; mem_wdata = wd;
         if_req  = (if_at >= 0) && (e >= if_at) && (e <= drop_if);
         b_mem   = (mem_at >= 0) && (e >= mem_at) && (e <= v_mem);
         mem_rd  = b_mem && (!m_wr || m_both);
         mem_wr  = b_mem && m_wr;
         if_kill = (kill_e >= 0) && (e == kill_e);
         @(posedge clk); #1;
         b_if   = (if_s >= 0) && (e >= if_s) && (e < if_s + lat);
         b_mem  = (mem_s >= 0) && (e >= mem_s) && (e < mem_s + lat);
         x_en   = b_if || b_mem;
         x_wr   = b_mem && m_wr;
         x_addr = b_mem ? ma : ia;
         x_ifv  = (if_s >= 0) && !killed && (e == v_if);
         x_memv = (mem_s >= 0) && (e == v_mem);
         if (x_ifv) exp_if_data[sel] = if_exp;
         if (x_memv && !m_wr) exp_mem_rdata[sel] = mem_exp;
         x_iff = if_req && !x_ifv;
         x_mf  = (mem_rd || mem_wr) && !x_memv;
         if (ob_if_valid && ov_if < 0) ov_if = e;
         if (ob_mem_valid && ov_mem < 0) ov_mem = e;
         o_en += int'(ob_ram_en);
         o_wr += int'(ob_ram_wr);
         n_vec += 8;
         if (ob_ram_en !== x_en) begin n_err++; $display("FAIL ram_en sel=%0d e=%0d got=%b exp=%b", sel, e, ob_ram_en, x_en); end
         if (ob_ram_wr !== x_wr) begin n_err++; $display("FAIL ram_wr sel=%0d e=%0d got=%b exp=%b", sel, e, ob_ram_wr, x_wr); end
         if (ob_if_valid !== x_ifv) begin n_err++; $display("FAIL if_valid sel=%0d e=%0d got=%b exp=%b", sel, e, ob_if_valid, x_ifv); end
         if (ob_mem_valid !== x_memv) begin n_err++; $display("FAIL mem_valid sel=%0d e=%0d got=%b exp=%b", sel, e, ob_mem_valid, x_memv); end
         if (ob_if_freeze !== x_iff) begin n_err++; $display("FAIL if_freeze sel=%0d e=%0d got=%b exp=%b", sel, e, ob_if_freeze, x_iff); end
         if (ob_mem_freeze !== x_mf) begin n_err++; $display("FAIL mem_freeze sel=%0d e=%0d got=%b exp=%b", sel, e, ob_mem_freeze, x_mf); end
         if (ob_if_data !== exp_if_data[sel]) begin n_err++; $display("FAIL if_data sel=%0d e=%0d got=%h exp=%h", sel, e, ob_if_data, exp_if_data[sel]); end
         if (ob_mem_rdata !== exp_mem_rdata[sel]) begin n_err++; $display("FAIL mem_rdata sel=%0d e=%0d got=%h exp=%h", sel, e, ob_mem_rdata, exp_mem_rdata[sel]); end
         if (x_en) begin
            n_vec++;
            if (ob_ram_addr !== x_addr) begin n_err++; $display("FAIL ram_addr sel=%0d e=%0d got=%h exp=%h", sel, e, ob_ram_addr, x_addr); end
         end
         if (x_wr) begin
            n_vec++;
            if (ob_ram_wdata !== wd) begin n_err++; $display("FAIL ram_wdata sel=%0d e=%0d got=%h exp=%h", sel, e, ob_ram_wdata, wd); end
         end
         @(negedge clk);
      end
      if_req = 1'b0; if_kill = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 2'd0;
      if_req = 1'b0; if_kill = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(32'(i) << 2);
      for (int k = 0; k < 3; k++) begin exp_if_data[k] = '0; exp_mem_rdata[k] = '0; end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k); #1;
         n_vec += 4;
         if ({ob_ram_en, ob_ram_wr, ob_if_valid, ob_mem_valid} !== 4'b0) begin n_err++; $display("FAIL reset_strobes sel=%0d got=%b exp=0000", k, {ob_ram_en, ob_ram_wr, ob_if_valid, ob_mem_valid}); end
         if ({ob_if_data, ob_mem_rdata, ob_ram_addr, ob_ram_wdata} !== 128'b0) begin n_err++; $display("FAIL reset_data sel=%0d got=%h exp=0", k, {ob_if_data, ob_mem_rdata, ob_ram_addr, ob_ram_wdata}); end
         if (ob_state !== 3'(IDLE)) begin n_err++; $display("FAIL reset_state sel=%0d got=%0d exp=%0d", k, ob_state, 3'(IDLE)); end
         if (ob_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt sel=%0d got=%0d exp=0", k, ob_cnt); end
      end
      sel = 2'd0;
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_fetch();
      int vi, vm, en, wr;
      sel = 2'd0;
      run_scn(0, -1, 0, 0, 32'h10, 32'h0, 32'h0, -99, vi, vm, en, wr);
      n_vec += 3;
      if (vi !== 2) begin n_err++; $display("FAIL fetch_latency got=%0d exp=2", vi); end
      if (en !== 2) begin n_err++; $display("FAIL fetch_busy_len got=%0d exp=2", en); end
      if (ob_if_data !== 32'hE3A01005) begin n_err++; $display("FAIL fetch_data got=%h exp=e3a01005", ob_if_data); end
   endtask

   task automatic test_contention();
      int vi, vm, en, wr;
      sel = 2'd0;
      run_scn(0, 0, 0, 0, 32'h14, 32'h400, 32'h0, -99, vi, vm, en, wr);
      n_vec += 4;
      if (vm !== 2) begin n_err++; $display("FAIL contend_mem_valid got=%0d exp=2", vm); end
      if (vi !== 6) begin n_err++; $display("FAIL contend_if_valid got=%0d exp=6", vi); end
      if (en !== 4) begin n_err++; $display("FAIL contend_busy got=%0d exp=4", en); end
      if (ob_mem_rdata !== 32'h55) begin n_err++; $display("FAIL contend_rdata got=%h exp=55", ob_mem_rdata); end
   endtask

   task automatic test_store();
      int vi, vm, en, wr;
      sel = 2'd0;
      run_scn(-1, 0, 1, 0, 32'h0, 32'h404, 32'hDEADBEEF, -99, vi, vm, en, wr);
      n_vec += 3;
      if (wr !== 2) begin n_err++; $display("FAIL store_wr_len got=%0d exp=2", wr); end
      if (vm !== 2) begin n_err++; $display("FAIL store_valid got=%0d exp=2", vm); end
      if (ob_mem_rdata !== 32'h55) begin n_err++; $display("FAIL store_rdata_held got=%h exp=55", ob_mem_rdata); end
      // Read back; rd_en and wr_en together must behave as a store.
      run_scn(-1, 0, 1, 1, 32'h0, 32'h408, 32'h0BADF00D, -99, vi, vm, en, wr);
      n_vec++;
      if (wr !== 2) begin n_err++; $display("FAIL both_en_store got=%0d exp=2", wr); end
      run_scn(-1, 0, 0, 0, 32'h0, 32'h404, 32'h0, -99, vi, vm, en, wr);
      n_vec++;
      if (ob_mem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_readback got=%h exp=deadbeef", ob_mem_rdata); end
   endtask

   task automatic test_kill();
      int vi, vm, en, wr;
      sel = 2'd0;
      run_scn(0, -1, 0, 0, 32'h10, 32'h0, 32'h0, -99, vi, vm, en, wr);
      run_scn(0, -1, 0, 0, 32'h18, 32'h0, 32'h0, 1, vi, vm, en, wr);
      n_vec += 3;
      if (vi !== -1) begin n_err++; $display("FAIL kill_valid got=%0d exp=-1", vi); end
      if (en !== 2) begin n_err++; $display("FAIL kill_busy got=%0d exp=2", en); end
      if (ob_if_data !== 32'hE3A01005) begin n_err++; $display("FAIL kill_data_held got=%h exp=e3a01005", ob_if_data); end
      run_scn(0, -1, 0, 0, 32'h20, 32'h0, 32'h0, -99, vi, vm, en, wr);
      n_vec += 2;
      if (vi !== 2) begin n_err++; $display("FAIL after_kill_valid got=%0d exp=2", vi); end
      if (ob_if_data !== 32'h12345678) begin n_err++; $display("FAIL after_kill_data got=%h exp=12345678", ob_if_data); end
   endtask

   task automatic test_sweep();
      int vi, vm, en, wr;
      sel = 2'd1;
      run_scn(0, -1, 0, 0, 32'h10, 32'h0, 32'h0, -99, vi, vm, en, wr);
      n_vec += 2;
      if (vi !== 1) begin n_err++; $display("FAIL lat1_valid got=%0d exp=1", vi); end
      if (en !== 1) begin n_err++; $display("FAIL lat1_busy got=%0d exp=1", en); end
      sel = 2'd2;
      run_scn(-1, 0, 0, 0, 32'h0, 32'h400, 32'h0, -99, vi, vm, en, wr);
      n_vec += 2;
      if (vm !== 15) begin n_err++; $display("FAIL lat15_valid got=%0d exp=15", vm); end
      if (en !== 15) begin n_err++; $display("FAIL lat15_busy got=%0d exp=15", en); end
   endtask

   task automatic test_random(input int n);
      int vi, vm, en, wr, kind, lat, if_at, mem_at, kill_off;
      bit m_wr, m_both;
      logic [31:0] ia, ma, wd;
      for (int i = 0; i < n; i++) begin
         sel  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
         lat  = lat_of(sel);
         kind = int'($urandom_range(0, 4));
         ia   = 32'h100 + 32'($urandom_range(0, 7)) * 4;
         ma   = 32'h100 + 32'($urandom_range(0, 7)) * 4;
         wd   = $urandom();
         m_wr = 1'b0; m_both = 1'b0; if_at = -1; mem_at = -1; kill_off = -99;
         case (kind)
            0: begin
               if_at = int'($urandom_range(0, 2));
               if ($urandom_range(0, 2) == 0) kill_off = int'($urandom_range(0, lat + 2)) - 1;
            end
            1: mem_at = int'($urandom_range(0, 2));
            2: begin mem_at = 0; m_wr = 1'b1; m_both = 1'($urandom_range(0, 1)); end
            3: begin if_at = 0; mem_at = 0; m_wr = 1'($urandom_range(0, 1)); end
            default: begin if_at = 0; mem_at = int'($urandom_range(1, lat + 3)); m_wr = 1'($urandom_range(0, 1)); end
         endcase
         run_scn(if_at, mem_at, m_wr, m_both, ia, ma, wd, kill_off, vi, vm, en, wr);
      end
   endtask

   task automatic test_reset_mid_access();
      sel = 2'd0;
      mem_wr = 1'b1; mem_addr = 32'h404; mem_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      n_vec++;
      if ({ob_ram_en, ob_ram_wr} !== 2'b11) begin n_err++; $display("FAIL midrst_busy got=%b exp=11", {ob_ram_en, ob_ram_wr}); end
      @(negedge clk);
      rst = 1'b1; #1;
      n_vec += 4;
      if ({ob_ram_en, ob_ram_wr, ob_mem_valid, ob_if_valid} !== 4'b0) begin n_err++; $display("FAIL midrst_strobes got=%b exp=0000", {ob_ram_en, ob_ram_wr, ob_mem_valid, ob_if_valid}); end
      if ({ob_if_data, ob_mem_rdata, ob_ram_addr, ob_ram_wdata} !== 128'b0) begin n_err++; $display("FAIL midrst_data got=%h exp=0", {ob_if_data, ob_mem_rdata, ob_ram_addr, ob_ram_wdata}); end
      if (ob_state !== 3'(IDLE)) begin n_err++; $display("FAIL midrst_state got=%0d exp=%0d", ob_state, 3'(IDLE)); end
      if (ob_cnt !== 4'd0) begin n_err++; $display("FAIL midrst_cnt got=%0d exp=0", ob_cnt); end
      mem_wr = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_vec += 2;
      if (ob_state !== 3'(IDLE)) begin n_err++; $display("FAIL postrst_state got=%0d exp=%0d", ob_state, 3'(IDLE)); end
      if (ob_ram_en !== 1'b0) begin n_err++; $display("FAIL postrst_ram_en got=%b exp=0", ob_ram_en); end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_contention();
      test_store();
      test_kill();
      test_sweep();
      test_random(120);
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
Shares one single-ported unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store). It sequences each RAM access over a fixed number of wait cycles. It drives the freeze signals that stall the IF PC register and the MEM stage until their access completes. MEM has priority over IF because it belongs to the older instruction.

Parameters:
ADDR_W, 32, address width for both requesters and the RAM
DATA_W, 32, data width
MEM_LAT, 2, RAM access cycles per transfer (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address (PC)
if_kill  in  1  branch taken; discard the in-flight fetch result
if_data  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle completion pulse for a fetch
if_freeze  out  1  stall for the PC register (feeds freeze)
mem_rd_en  in  1  load request, level
mem_wr_en  in  1  store request, level
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered
mem_valid  out  1  one-cycle completion pulse for a load or store
mem_freeze  out  1  stall for the pipeline at the MEM stage
ram_en  out  1  RAM access strobe
ram_wr  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address, held for the whole access
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid by the last access cycle

Behaviour:
- Reset (async, rst=1) forces the following immediately, including mid-access:
  - state=IDLE, cnt=0;
  - ram_en=ram_wr=0, if_valid=mem_valid=0;
  - if_data=mem_rdata=ram_addr=ram_wdata=0; the kill flag is cleared.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM. All transitions occur on the rising clk edge.
- IDLE:
  - If mem_rd_en|mem_wr_en, go to BUSY_MEM: latch mem_addr, mem_wdata and the write flag (mem_wr_en).
  - Else if if_req, go to BUSY_IF: latch if_addr.
  - On either transition load cnt=MEM_LAT-1.
- BUSY_x:
  - ram_en=1; ram_addr and ram_wdata come from the latched values.
  - ram_wr=1 for all cycles of a store, 0 otherwise.
  - cnt decrements each cycle. When cnt==0, sample ram_rdata into if_data or mem_rdata (loads only) and go to DONE_x.
- DONE_x: the matching valid=1 for exactly one cycle, then go to IDLE. No back-to-back start from DONE.
- Store: mem_rdata is unchanged; mem_valid still pulses.
- Timing: a request sampled in IDLE at edge t gives BUSY for cycles t+1..t+MEM_LAT and valid in cycle t+MEM_LAT+1. Occupancy is MEM_LAT+2 cycles per access.
- Freeze outputs (combinational from registered state):
  - if_freeze = if_req & ~if_valid.
  - mem_freeze = (mem_rd_en|mem_wr_en) & ~mem_valid.
- Simultaneous IF and MEM requests in IDLE: MEM is served; if_freeze stays 1 until IF is served afterwards.
- mem_rd_en and mem_wr_en both 1: treated as a store.
- if_kill:
  - If asserted in any BUSY_IF cycle, or at the edge entering it, set a kill flag.
  - The access runs to completion (the RAM is not aborted) and DONE_IF is still entered.
  - if_valid stays 0 and if_data is not updated. The flag clears in DONE_IF.
  - if_kill in IDLE has no effect.
- Requests dropped mid-access: the access completes and valid pulses anyway; requesters must hold requests, and the block does not check this.
- Output data registers hold their value until the next completing access of the same kind.

Decomposition:
- Shared package:
  - state enum (arb_state_t: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM);
  - CNT_W=4 constant;
  - arbiter-owner encoding (OWN_IF, OWN_MEM).
- One natural sub-module, lat_counter: a loadable down-counter with a zero flag, parameterised by width.

Test Plan:
1. Reset: assert rst mid BUSY_MEM store -> ram_en, ram_wr, mem_valid drop the same cycle, all data outputs read 0, state IDLE after release.
2. Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10 sampled at edge 0; ram returns 0xE3A01005 -> ram_en=1 with ram_addr=0x10 in cycles 1-2, if_valid=1 with if_data=0xE3A01005 in cycle 3, if_freeze=1 in cycles 0-2 and 0 in cycle 3.
3. Contention: if_req and mem_rd_en (addr 0x400, rdata 0x55) both raised at edge 0 -> mem_valid with mem_rdata=0x55 in cycle 3, IF access starts cycle 5, if_valid in cycle 7, if_freeze=1 in cycles 0-6.
4. Store: mem_wr_en, addr 0x404, wdata 0xDEADBEEF -> ram_wr=1 exactly MEM_LAT cycles with that address and data, mem_valid pulse, mem_rdata unchanged.
5. Kill: if_kill pulsed in cycle 1 of a fetch -> no if_valid, if_data keeps its old value, next fetch of addr 0x20 completes normally.
6. Parameter sweep: MEM_LAT=1 and MEM_LAT=15 -> BUSY length equals MEM_LAT, valid at t+MEM_LAT+1.
